// File: rtl/gry_bin_sync_pkg.sv
// Shared constants and helpers for the Gray-to-binary synchroniser.
// Helpers operate on a fixed MAX_W width; callers zero-extend and truncate.
package gry_bin_sync_pkg;

    localparam int DEF_N           = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_W           = 32;
    localparam int CNT_W           = 6;

    // Zero-extended inputs keep the upper result bits at zero,
    // so truncating the result gives the exact narrow conversion.
    function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gry_bin_sync_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus crossing into clk.
module sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the asynchronous input through the synchroniser stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gry_bin_sync.sv
// Synchronises a Gray-coded count, converts it to binary and reports the
// per-step delta, a change pulse and a sticky multi-bit-step error.
module gry_bin_sync
    import gry_bin_sync_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] gray_in,
    input  logic         err_clr,
    output logic [N-1:0] gray_sync,
    output logic [N-1:0] binary,
    output logic [N-1:0] delta,
    output logic         changed,
    output logic         err
);

    logic [N-1:0] gray_sync_s;
    logic [N-1:0] bin_now_s;
    logic         diff_s;
    logic         jump_s;
    logic         valid_s;

    logic [2:0]   cnt_q,       cnt_d;
    logic         primed_q,    primed_d;
    logic [N-1:0] binary_q,    binary_d;
    logic [N-1:0] gray_prev_q, gray_prev_d;
    logic [N-1:0] bin_prev_q,  bin_prev_d;
    logic [N-1:0] delta_q,     delta_d;
    logic         changed_q,   changed_d;
    logic         err_q,       err_d;

    sync_chain #(
        .WIDTH  (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gray_in),
        .q_o   (gray_sync_s)
    );

    assign bin_now_s = N'(gray_to_bin(MAX_W'(gray_sync_s)));
    assign diff_s    = (gray_sync_s != gray_prev_q);
    assign jump_s    = (popcount(MAX_W'(gray_sync_s ^ gray_prev_q)) > CNT_W'(1));
    assign valid_s   = (cnt_q == 3'(SYNC_STAGES));

    // Next-state logic; compare against the previous sample only once primed.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q | valid_s;
        binary_d    = bin_now_s;
        gray_prev_d = gray_sync_s;
        bin_prev_d  = bin_now_s;
        changed_d   = 1'b0;
        delta_d     = delta_q;
        err_d       = err_q;

        if (!valid_s) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (primed_q && diff_s) begin
            changed_d = 1'b1;
            delta_d   = bin_now_s - bin_prev_q;
        end else begin
            changed_d = 1'b0;
            delta_d   = delta_q;
        end

        // A new error takes priority over a simultaneous clear.
        if (primed_q && diff_s && jump_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; all outputs are driven straight from these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 3'd0;
            primed_q    <= 1'b0;
            binary_q    <= {N{1'b0}};
            gray_prev_q <= {N{1'b0}};
            bin_prev_q  <= {N{1'b0}};
            delta_q     <= {N{1'b0}};
            changed_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            binary_q    <= binary_d;
            gray_prev_q <= gray_prev_d;
            bin_prev_q  <= bin_prev_d;
            delta_q     <= delta_d;
            changed_q   <= changed_d;
            err_q       <= err_d;
        end
    end

    assign gray_sync = gray_sync_s;
    assign binary    = binary_q;
    assign delta     = delta_q;
    assign changed   = changed_q;
    assign err       = err_q;

endmodule

// File: tb/tb_gry_bin_sync.sv
// Directed self-checking bench for gry_bin_sync with default parameters.
module tb_gry_bin_sync;

    logic       clk;
    logic       rst_n;
    logic [7:0] gray_in;
    logic       err_clr;
    logic [7:0] gray_sync;
    logic [7:0] binary;
    logic [7:0] delta;
    logic       changed;
    logic       err;

    int checks_cnt;
    int errors_cnt;

    gry_bin_sync dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gray_in   (gray_in),
        .err_clr   (err_clr),
        .gray_sync (gray_sync),
        .binary    (binary),
        .delta     (delta),
        .changed   (changed),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_prime(input logic [7:0] g);
        rst_n   = 1'b0;
        gray_in = g;
        #2;
        rst_n   = 1'b1;
        repeat (4) tick();
    endtask

    logic [7:0] kk;
    logic [7:0] gk;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n   = 1'b0;
        gray_in = 8'h07;
        err_clr = 1'b0;

        // Reset state and priming with 8'h07
        #12;
        chk("rst_gray", gray_sync, 8'h00);
        chk("rst_bin", binary, 8'h00);
        chk("rst_delta", delta, 8'h00);
        chk("rst_chg", 8'(changed), 8'h00);
        chk("rst_err", 8'(err), 8'h00);
        rst_n = 1'b1;
        tick();
        chk("prime_gray_early", gray_sync, 8'h00);
        tick();
        chk("prime_gray", gray_sync, 8'h07);
        chk("prime_chg0", 8'(changed), 8'h00);
        tick();
        chk("prime_bin", binary, 8'h05);
        chk("prime_chg", 8'(changed), 8'h00);
        chk("prime_err", 8'(err), 8'h00);
        chk("prime_delta", delta, 8'h00);

        // Counting sequence 1..15 in Gray code
        reset_prime(8'h00);
        chk("cnt_base", binary, 8'h00);
        for (int k = 1; k < 16; k++) begin
            kk = 8'(k);
            gk = kk ^ (kk >> 1);
            gray_in = gk;
            repeat (3) tick();
            chk("cnt_chg", 8'(changed), 8'h01);
            chk("cnt_bin", binary, kk);
            chk("cnt_delta", delta, 8'h01);
            chk("cnt_err", 8'(err), 8'h00);
            tick();
            chk("cnt_pulse_end", 8'(changed), 8'h00);
            chk("cnt_delta_hold", delta, 8'h01);
        end

        // Wrap-around in both directions
        reset_prime(8'h80);
        chk("wrap_base", binary, 8'hFF);
        gray_in = 8'h00;
        repeat (3) tick();
        chk("wrap_up_chg", 8'(changed), 8'h01);
        chk("wrap_up_bin", binary, 8'h00);
        chk("wrap_up_delta", delta, 8'h01);
        chk("wrap_up_err", 8'(err), 8'h00);
        tick();
        gray_in = 8'h80;
        repeat (3) tick();
        chk("wrap_dn_bin", binary, 8'hFF);
        chk("wrap_dn_delta", delta, 8'hFF);
        chk("wrap_dn_err", 8'(err), 8'h00);
        tick();

        // Two-bit jump sets sticky error; err_clr clears it
        gray_in = 8'h00;
        repeat (4) tick();
        gray_in = 8'hC0;
        repeat (3) tick();
        chk("jump_chg", 8'(changed), 8'h01);
        chk("jump_err", 8'(err), 8'h01);
        chk("jump_bin", binary, 8'h80);
        chk("jump_delta", delta, 8'h80);
        repeat (3) tick();
        chk("jump_sticky", 8'(err), 8'h01);
        err_clr = 1'b1;
        chk("jump_before_clr", 8'(err), 8'h01);
        tick();
        err_clr = 1'b0;
        chk("jump_cleared", 8'(err), 8'h00);

        // Clear coinciding with a new error: set wins
        gray_in = 8'h40;
        repeat (4) tick();
        chk("coll_pre_err", 8'(err), 8'h00);
        chk("coll_pre_bin", binary, 8'h7F);
        gray_in = 8'hC3;
        repeat (2) tick();
        err_clr = 1'b1;
        tick();
        chk("coll_chg", 8'(changed), 8'h01);
        chk("coll_err", 8'(err), 8'h01);
        chk("coll_bin", binary, 8'h82);
        chk("coll_delta", delta, 8'h03);
        tick();
        err_clr = 1'b0;
        chk("coll_clr_after", 8'(err), 8'h00);

        // Asynchronous reset mid-operation
        gray_in = 8'h3F;
        repeat (4) tick();
        chk("mid_bin", binary, 8'h2A);
        chk("mid_err", 8'(err), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gray", gray_sync, 8'h00);
        chk("arst_bin", binary, 8'h00);
        chk("arst_delta", delta, 8'h00);
        chk("arst_chg", 8'(changed), 8'h00);
        chk("arst_err", 8'(err), 8'h00);
        tick();
        chk("arst_hold", gray_sync, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("post_rst_chg", 8'(changed), 8'h00);
            chk("post_rst_delta", delta, 8'h00);
        end
        chk("post_rst_bin", binary, 8'h2A);
        chk("post_rst_err", 8'(err), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
